// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the
// downstream video pipeline stages (background/menu, game logic).
interface vga_timing_if;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        frame_start_out;

    // Producer side: the timing generator drives every field.
    modport master (
        output hcount_out,
        output vcount_out,
        output hsync_out,
        output vsync_out,
        output hblnk_out,
        output vblnk_out,
        output frame_start_out
    );

    // Consumer side: pipeline stages only observe the raster.
    modport slave (
        input hcount_out,
        input vcount_out,
        input hsync_out,
        input vsync_out,
        input hblnk_out,
        input vblnk_out,
        input frame_start_out
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (default 800x600 @ 60 Hz,
// 40 MHz pixel clock). Produces pixel/line counters, sync pulses,
// blanking flags and a one-cycle frame-start strobe. Every output is a
// register loaded from the next counter value, so flags always describe
// the counter values visible in the same cycle.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide; larger rasters cannot be represented.
    if ((H_TOTAL > 32'd2048) || (V_TOTAL > 32'd2048)) begin : g_total_too_large
        $fatal(1, "vga_timing: H_TOTAL and V_TOTAL must both be <= 2048");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 32'd1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 32'd1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 32'd1);
    localparam logic        HS_ACT_LVL = (HS_POL != 32'd0) ? 1'b1 : 1'b0;
    localparam logic        VS_ACT_LVL = (VS_POL != 32'd0) ? 1'b1 : 1'b0;

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        hblnk_r;
    logic        vblnk_r;
    logic        frame_start_r;

    logic        h_wrap_s;
    logic        v_wrap_s;
    logic [10:0] hcount_nxt_s;
    logic [10:0] vcount_nxt_s;
    logic        hsync_nxt_s;
    logic        vsync_nxt_s;
    logic        hblnk_nxt_s;
    logic        vblnk_nxt_s;
    logic        frame_start_nxt_s;

    // Next raster position: pixel counter wraps at line end, line counter
    // steps only on that wrap and itself wraps at frame end.
    always_comb begin
        h_wrap_s     = 1'b0;
        v_wrap_s     = 1'b0;
        hcount_nxt_s = 11'd0;
        vcount_nxt_s = 11'd0;

        h_wrap_s = (hcount_r == H_LAST);
        v_wrap_s = (vcount_r == V_LAST);

        if (h_wrap_s) begin
            hcount_nxt_s = 11'd0;
        end else begin
            hcount_nxt_s = hcount_r + 11'd1;
        end

        if (h_wrap_s) begin
            if (v_wrap_s) begin
                vcount_nxt_s = 11'd0;
            end else begin
                vcount_nxt_s = vcount_r + 11'd1;
            end
        end else begin
            vcount_nxt_s = vcount_r;
        end
    end

    // Flags decoded from the next position so they land in the same cycle
    // as the counter values they describe.
    always_comb begin
        hblnk_nxt_s       = 1'b0;
        vblnk_nxt_s       = 1'b0;
        hsync_nxt_s       = ~HS_ACT_LVL;
        vsync_nxt_s       = ~VS_ACT_LVL;
        frame_start_nxt_s = 1'b0;

        hblnk_nxt_s = (hcount_nxt_s >= H_ACT_END);
        vblnk_nxt_s = (vcount_nxt_s >= V_ACT_END);

        if ((hcount_nxt_s >= HS_FIRST) && (hcount_nxt_s <= HS_LAST)) begin
            hsync_nxt_s = HS_ACT_LVL;
        end else begin
            hsync_nxt_s = ~HS_ACT_LVL;
        end

        if ((vcount_nxt_s >= VS_FIRST) && (vcount_nxt_s <= VS_LAST)) begin
            vsync_nxt_s = VS_ACT_LVL;
        end else begin
            vsync_nxt_s = ~VS_ACT_LVL;
        end

        // Only the frame wrap edge produces the strobe; the reset state is
        // pixel (0,0) of frame 0 but never carries a strobe.
        if (h_wrap_s && v_wrap_s) begin
            frame_start_nxt_s = 1'b1;
        end else begin
            frame_start_nxt_s = 1'b0;
        end
    end

    // Raster state and registered outputs; reset forces the idle raster
    // immediately, independent of the pixel clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            hsync_r       <= ~HS_ACT_LVL;
            vsync_r       <= ~VS_ACT_LVL;
            hblnk_r       <= 1'b0;
            vblnk_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= hcount_nxt_s;
            vcount_r      <= vcount_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            hblnk_r       <= hblnk_nxt_s;
            vblnk_r       <= vblnk_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign vga.hcount_out      = hcount_r;
    assign vga.vcount_out      = vcount_r;
    assign vga.hsync_out       = hsync_r;
    assign vga.vsync_out       = vsync_r;
    assign vga.hblnk_out       = hblnk_r;
    assign vga.vblnk_out       = vblnk_r;
    assign vga.frame_start_out = frame_start_r;

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster timing generator for the 800x600 @ 60 Hz mode at a 40 MHz pixel clock. It is the first stage of the video pipeline. It produces the horizontal and vertical pixel counters, sync pulses and blanking flags. The background/menu stage consumes these through its `hcount_in`/`vcount_in`/`hsync_in`/`vsync_in`/`hblnk_in`/`vblnk_in` inputs. It also produces a one-cycle frame-start strobe that game-logic blocks use to update once per frame.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, active level of `hsync_out` (1 = active-high)
- `VS_POL`, 1, active level of `vsync_out`

Ports:
- `clk`  in  1  pixel clock, 40 MHz
- `rst`  in  1  reset; one clock; asynchronous, active-low (0 = reset)
- `hcount_out`  out  11  current pixel column, 0..H_TOTAL-1
- `vcount_out`  out  11  current line, 0..V_TOTAL-1
- `hsync_out`  out  1  horizontal sync, polarity per `HS_POL`
- `vsync_out`  out  1  vertical sync, polarity per `VS_POL`
- `hblnk_out`  out  1  high outside the visible columns
- `vblnk_out`  out  1  high outside the visible lines
- `frame_start`  out  1  one-cycle strobe at raster position (0,0)

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1056 by default.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 628 by default.
  - Both totals must be ≤2048 so they fit in 11 bits. Elaboration fails otherwise.
- Horizontal counter advances by 1 on every rising `clk` edge while `rst`=1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter advances by 1 only on the edge where hcount wraps.
  - At V_TOTAL-1, coincident with the hcount wrap, it wraps to 0.
- No other state and no enable input; the generator never stalls.
- All outputs are registered. Flags are computed from the next counter values so that in every cycle they describe the `hcount_out`/`vcount_out` shown in that same cycle:
  - `hblnk_out` = (hcount ≥ H_ACTIVE)
  - `vblnk_out` = (vcount ≥ V_ACTIVE)
  - `hsync_out` = active level iff H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1 (defaults: 840..967)
  - `vsync_out` = active level iff V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1 (defaults: 601..604)
  - `frame_start` = 1 iff (hcount,vcount) = (0,0), set by the wrap edge only. It is not set by reset.
- Vertical sync/blank change only at hcount = 0 (line boundaries).

## Timing
- Reset values, forced immediately on the falling edge of `rst`, independent of `clk`:
  - `hcount_out`=0, `vcount_out`=0
  - `hblnk_out`=0, `vblnk_out`=0
  - `hsync_out`=~HS_POL, `vsync_out`=~VS_POL
  - `frame_start`=0
- First rising edge after `rst` rises: hcount 0→1. The reset state counts as pixel (0,0) of frame 0, so frame 0 has no `frame_start`.
- Latency: zero between counters and flags (same-cycle alignment). Downstream stages add their own delay.
- Line period is H_TOTAL cycles (1056). Frame period is H_TOTAL×V_TOTAL cycles (663168).
- `frame_start` is high for exactly 1 cycle per frame.
  - It is first seen 663168 edges after reset release, coinciding with hcount=0, vcount=0.
- Reset mid-frame: all outputs return to their reset values asynchronously. Counting restarts from (0,0) on release with no partial pulses.
- Simultaneous hcount wrap and vcount wrap (1055,627)→(0,0): vsync stays inactive, vblnk falls to 0, hblnk falls to 0, and `frame_start` rises, all on the same edge.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles, then assert `rst`=0 asynchronously mid-cycle while running. → All outputs show their reset values immediately. After release, hcount reads 1,2,3… on successive edges.
- **Horizontal timing:** run one line from reset.
  - `hblnk_out` rises exactly when hcount=800 and falls at 0.
  - `hsync_out`=1 for exactly 128 cycles, hcount 840..967.
  - hcount 1055→0 and vcount 0→1 on the same edge.
- **Vertical timing:** run one full frame.
  - `vblnk_out`=1 for vcount 600..627.
  - `vsync_out`=1 for exactly 4×1056 = 4224 cycles, vcount 601..604.
  - Both change only when hcount=0.
- **Frame strobe:** run 3 frames. → `frame_start` pulses exactly 2 times, each 1 cycle wide, spaced 663168 cycles apart, each at (0,0).
- **Polarity parameters:** instantiate with HS_POL=0, VS_POL=0. → Syncs idle high, including during reset, and go low over the same windows as above.
- **Alternate mode:** instantiate 640x480 (H 640/16/96/48, V 480/10/2/33).
  - Line period is 800 cycles and frame period is 420000 cycles.
  - hsync window is hcount 656..751; vsync window is vcount 490..491.
